// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The memory is 256 words addressed by a 10-bit byte address, same as the ROM.
package imem_pkg;

   localparam int ADDR_W         = 10;
   localparam int DATA_W         = 32;
   localparam int DEPTH          = 256;
   localparam int BYTES_PER_WORD = 4;
   localparam int IDX_W          = ADDR_W - 2;
   localparam int CNT_W          = IDX_W + 1;

   localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE
   } state_t;

   // True when a load of num words starting at word idx stays inside the memory.
   function automatic logic range_ok(input logic [IDX_W-1:0] idx,
                                     input logic [CNT_W-1:0] num);
      logic [ADDR_W-1:0] last_plus_one;
      last_plus_one = {2'b00, idx} + {1'b0, num};
      return last_plus_one <= DEPTH_LIMIT;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four consecutive bytes into one big-endian 32-bit word.
// Byte k of a word lands in word[31-8k -: 8]; word_ready flags the 4th byte.
module byte_packer
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic [DATA_W-1:0] word,
   output logic              word_ready
);

   logic [1:0]        byte_cnt_reg;
   logic [DATA_W-1:0] word_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         byte_cnt_reg <= 2'd0;
      end else if (byte_valid) begin
         byte_cnt_reg <= byte_cnt_reg + 2'd1;
      end
   end

   // One register lane per byte position, loaded when the counter points at it.
   for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      always_ff @(posedge clk) begin
         if (reset || clear) begin
            word_reg[DATA_W-1-8*gi -: 8] <= 8'h00;
         end else if (byte_valid && (byte_cnt_reg == 2'(gi))) begin
            word_reg[DATA_W-1-8*gi -: 8] <= byte_data;
         end
      end
   end

   assign word       = word_reg;
   assign word_ready = byte_valid && (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the writable instruction memory one packed word at a time,
// holding the CPU for the whole load.
module imem_loader
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]  num_words,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  words_written
);

   state_t            state_reg, state_next;
   logic              err_next;
   logic [IDX_W-1:0]  index_reg;
   logic [CNT_W-1:0]  words_left_reg;
   logic [CNT_W-1:0]  words_written_reg;
   logic              in_ready_reg;
   logic              wr_en_reg;
   logic              cpu_hold_reg;
   logic              done_reg;
   logic              err_reg;

   logic              start_idle;
   logic              start_ok;
   logic              byte_fire;
   logic              word_ready;
   logic [DATA_W-1:0] packed_word;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^start_addr[1:0];

   assign start_idle = (state_reg == IDLE) && start;
   assign start_ok   = range_ok(start_addr[ADDR_W-1:2], num_words);
   // Abort wins over a byte offered in the same cycle.
   assign byte_fire  = (state_reg == LOAD) && in_valid && !abort;

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_idle),
      .byte_valid (byte_fire),
      .byte_data  (in_data),
      .word       (packed_word),
      .word_ready (word_ready)
   );

   always_comb begin
      state_next = state_reg;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (!start_ok) begin
                  err_next = 1'b1;
               end else if (num_words == '0) begin
                  state_next = DONE;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else if (word_ready) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            if (abort) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else if (words_left_reg == CNT_W'(1)) begin
               state_next = DONE;
            end else begin
               state_next = LOAD;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs are decodes of the next state so they line up with state_reg.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         in_ready_reg <= 1'b0;
         wr_en_reg    <= 1'b0;
         cpu_hold_reg <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next == LOAD);
         wr_en_reg    <= (state_next == WRITE);
         cpu_hold_reg <= (state_next != IDLE);
         done_reg     <= (state_next == DONE);
         err_reg      <= err_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         index_reg         <= '0;
         words_left_reg    <= '0;
         words_written_reg <= '0;
      end else if (start_idle && start_ok) begin
         index_reg         <= start_addr[ADDR_W-1:2];
         words_left_reg    <= num_words;
         words_written_reg <= '0;
      end else if ((state_reg == WRITE) && !abort) begin
         // The range check at start keeps index_reg <= 255 for every write.
         index_reg         <= index_reg + IDX_W'(1);
         words_left_reg    <= words_left_reg - CNT_W'(1);
         words_written_reg <= words_written_reg + CNT_W'(1);
      end
   end

   assign in_ready      = in_ready_reg;
   assign wr_en         = wr_en_reg;
   assign wr_addr       = {index_reg, 2'b00};
   assign wr_data       = packed_word;
   assign cpu_hold      = cpu_hold_reg;
   assign done          = done_reg;
   assign err           = err_reg;
   assign words_written = words_written_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: transaction-level reference model,
// per-cycle compare, directed scenarios and randomized loads.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  start_addr = '0;
   logic [8:0]  num_words = '0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [8:0]  words_written;

   imem_loader dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .start_addr    (start_addr),
      .num_words     (num_words),
      .abort         (abort),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .err           (err),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   logic        exp_in_ready = 1'b0;
   logic        exp_wr_en = 1'b0;
   logic [9:0]  exp_wr_addr = '0;
   logic [31:0] exp_wr_data = '0;
   logic        exp_hold = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_err = 1'b0;
   logic [8:0]  exp_ww = '0;
   logic [7:0]  bq[$];
   int          m_next = 0;
   int          m_left = 0;
   bit          was_idle, was_load, was_write, was_done;
   int          first;

   always @(posedge clk) begin
      if (reset) begin
         exp_in_ready = 0; exp_wr_en = 0; exp_wr_addr = '0; exp_wr_data = '0;
         exp_hold = 0; exp_done = 0; exp_err = 0; exp_ww = '0;
         bq.delete(); m_next = 0; m_left = 0;
      end else begin
         was_idle  = !exp_hold;
         was_load  = exp_in_ready;
         was_write = exp_wr_en;
         was_done  = exp_done;
         exp_done  = 0;
         exp_err   = 0;
         exp_wr_en = 0;
         if (was_idle) begin
            if (start) begin
               first = int'(start_addr) / 4;
               if (first + int'(num_words) > 256) begin
                  exp_err = 1;
               end else begin
                  exp_hold = 1;
                  exp_ww   = '0;
                  m_next   = first;
                  m_left   = int'(num_words);
                  bq.delete();
                  if (num_words == 0) exp_done = 1;
                  else exp_in_ready = 1;
               end
            end
         end else if (was_done) begin
            exp_hold = 0;
         end else if (abort) begin
            exp_hold = 0;
            exp_in_ready = 0;
            exp_err = 1;
         end else if (was_load) begin
            if (in_valid) begin
               bq.push_back(in_data);
               if (bq.size() == 4) begin
                  exp_in_ready = 0;
                  exp_wr_en    = 1;
                  exp_wr_addr  = 10'(m_next * 4);
                  exp_wr_data  = {bq[0], bq[1], bq[2], bq[3]};
                  bq.delete();
               end
            end
         end else if (was_write) begin
            m_next++;
            m_left--;
            exp_ww = exp_ww + 9'd1;
            if (m_left == 0) exp_done = 1;
            else exp_in_ready = 1;
         end
      end
   end

   // ---------------- per-cycle compare + write log ----------------
   bit          check_en = 0;
   int          cyc = 0;
   int          done_cyc = -1;
   int          overlap = 0;
   logic [9:0]  wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];

   always @(negedge clk) begin
      if (check_en) begin
         chk("in_ready", in_ready, exp_in_ready);
         chk("wr_en", wr_en, exp_wr_en);
         chk("cpu_hold", cpu_hold, exp_hold);
         chk("done", done, exp_done);
         chk("err", err, exp_err);
         chk("words_written", words_written, exp_ww);
         if (exp_wr_en) begin
            chk("wr_addr", wr_addr, exp_wr_addr);
            chk("wr_data", wr_data, exp_wr_data);
         end
         if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
         end
         if (in_ready && wr_en) overlap++;
         if (done) done_cyc = cyc;
      end
      cyc++;
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic clear_log();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
      done_cyc = -1;
   endtask

   task automatic do_start(input logic [9:0] a, input logic [8:0] n);
      start = 1; start_addr = a; num_words = n;
      @(negedge clk);
      start = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc;
      int budget;
      in_valid = 1; in_data = b;
      budget = 0;
      acc = 0;
      while (!acc && budget < 20) begin
         acc = exp_in_ready;
         @(negedge clk);
         budget++;
      end
      if (!acc) chk("byte_accept_timeout", 0, 1);
      in_valid = 0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((cpu_hold || exp_hold) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("idle_timeout", 0, 1);
      @(negedge clk);
   endtask

   logic [7:0] prog[8];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      prog[0] = 8'h20; prog[1] = 8'h10; prog[2] = 8'h00; prog[3] = 8'h02;
      prog[4] = 8'h20; prog[5] = 8'h11; prog[6] = 8'h00; prog[7] = 8'h0A;

      @(posedge clk);
      check_en = 1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_ww", words_written, 0);
      reset = 0;
      @(negedge clk);

      // Back-to-back two-word load.
      clear_log();
      do_start(10'h028, 9'd2);
      for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
      wait_idle();
      chk("t1_nwrites", wa_q.size(), 2);
      if (wa_q.size() == 2) begin
         chk("t1_addr0", wa_q[0], 32'h028);
         chk("t1_data0", wd_q[0], 32'h20100002);
         chk("t1_addr1", wa_q[1], 32'h02C);
         chk("t1_data1", wd_q[1], 32'h2011000A);
         chk("t1_spacing", wc_q[1] - wc_q[0], 5);
         chk("t1_done_lat", done_cyc - wc_q[1], 1);
      end
      chk("t1_ww", words_written, 2);
      chk("t1_hold_after", cpu_hold, 0);

      // Same load with gapped bytes.
      clear_log();
      do_start(10'h028, 9'd2);
      for (int i = 0; i < 8; i++) send_byte(prog[i], 2);
      wait_idle();
      chk("t2_nwrites", wa_q.size(), 2);
      if (wa_q.size() == 2) begin
         chk("t2_addr0", wa_q[0], 32'h028);
         chk("t2_data0", wd_q[0], 32'h20100002);
         chk("t2_addr1", wa_q[1], 32'h02C);
         chk("t2_data1", wd_q[1], 32'h2011000A);
      end
      chk("t2_ready_in_write", overlap, 0);

      // Zero-word load.
      clear_log();
      do_start(10'h100, 9'd0);
      chk("t3_done", done, 1);
      chk("t3_hold", cpu_hold, 1);
      chk("t3_err", err, 0);
      @(negedge clk);
      chk("t3_done_after", done, 0);
      chk("t3_hold_after", cpu_hold, 0);
      chk("t3_nwrites", wa_q.size(), 0);

      // Out-of-range start.
      clear_log();
      do_start(10'h3FC, 9'd2);
      chk("t4_err", err, 1);
      chk("t4_hold", cpu_hold, 0);
      @(negedge clk);
      chk("t4_err_after", err, 0);
      chk("t4_nwrites", wa_q.size(), 0);

      // Abort after two bytes, then a clean reload.
      clear_log();
      do_start(10'h000, 9'd1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("t5_err", err, 1);
      chk("t5_hold", cpu_hold, 0);
      chk("t5_in_ready", in_ready, 0);
      do_start(10'h000, 9'd1);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      wait_idle();
      chk("t5_nwrites", wa_q.size(), 1);
      if (wa_q.size() == 1) begin
         chk("t5_addr", wa_q[0], 32'h000);
         chk("t5_data", wd_q[0], 32'hAABBCCDD);
      end

      // Reset in the middle of word 2.
      clear_log();
      do_start(10'h010, 9'd2);
      for (int i = 0; i < 7; i++) send_byte(prog[i], 0);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("t6_in_ready", in_ready, 0);
      chk("t6_wr_en", wr_en, 0);
      chk("t6_wr_addr", wr_addr, 0);
      chk("t6_wr_data", wr_data, 0);
      chk("t6_hold", cpu_hold, 0);
      chk("t6_ww", words_written, 0);
      repeat (8) @(negedge clk);
      chk("t6_nwrites", wa_q.size(), 1);

      // Randomized loads.
      for (int it = 0; it < 80; it++) begin
         logic [9:0] a;
         logic [8:0] n;
         int sel;
         bit stop;
         n = 9'($urandom_range(0, 5));
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = 10'((256 - int'(n)) * 4 + $urandom_range(0, 3));
         else if (sel == 1) a = 10'((257 - int'(n)) * 4 + $urandom_range(0, 3));
         else               a = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0) begin
            abort = 1;
            @(negedge clk);
            abort = 0;
         end
         do_start(a, n);
         stop = 0;
         for (int b = 0; b < 4 * int'(n) && exp_hold && !stop; b++) begin
            if (exp_in_ready && $urandom_range(0, 59) == 0) begin
               abort = 1;
               in_valid = 1'($urandom_range(0, 1));
               @(negedge clk);
               abort = 0;
               in_valid = 0;
               stop = 1;
            end else if ($urandom_range(0, 99) == 0) begin
               reset = 1;
               @(negedge clk);
               reset = 0;
               stop = 1;
            end else begin
               start = 1'($urandom_range(0, 9) == 0);
               send_byte(8'($urandom), $urandom_range(0, 2));
               start = 0;
            end
         end
         wait_idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
